// File: rtl/univ_shift_reg_pkg.sv
// ----------------------------------------------------------------------------
// usr_pkg: shared types for the universal shift register.
//   mode_t  : operation select carried on the MODE bus (HOLD/LOAD/SHL/SHR).
//   state_t : shift-counting FSM states (IDLE, ACTIVE, SPENT).
// ----------------------------------------------------------------------------
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_SHR  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_SPENT  = 2'd2
    } state_t;

endpackage : usr_pkg

// File: rtl/univ_shift_reg_if.sv
// ----------------------------------------------------------------------------
// univ_shift_reg_if: control/data bundle of the universal shift register.
//   en    : clock enable (low = all state holds)
//   mode  : operation select (mode_t)
//   rot   : rotate instead of shifting in sin
//   d     : parallel load word
//   sin   : serial input bit
//   q     : register contents
//   sout  : bit shifted out by the most recent shift
//   cnt   : shifts since last LOAD, saturating at WIDTH
//   done  : one-cycle pulse when the WIDTH-th shift completes
// Modports: master drives the controls, slave is the register itself.
// ----------------------------------------------------------------------------
interface univ_shift_reg_if
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             en;
    mode_t            mode;
    logic             rot;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic [CW-1:0]    cnt;
    logic             done;

    modport master (
        output en, mode, rot, d, sin,
        input  q, sout, cnt, done
    );

    modport slave (
        input  en, mode, rot, d, sin,
        output q, sout, cnt, done
    );

endinterface : univ_shift_reg_if

// File: rtl/univ_shift_reg_counter.sv
// ----------------------------------------------------------------------------
// usr_counter: saturating shift counter.
//   clk_i  : clock
//   rst_i  : synchronous reset, active-high
//   clr_i  : synchronous clear (has priority over increment)
//   inc_i  : increment request; ignored once the count reaches MAX
//   cnt_o  : current count
//   last_o : count is MAX-1, i.e. the next increment reaches terminal count
// ----------------------------------------------------------------------------
module usr_counter #(
    parameter int MAX = 8,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);

    localparam logic [CW-1:0] MAX_C  = CW'(MAX);
    localparam logic [CW-1:0] LAST_C = CW'(MAX - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    // Decoded from the count alone so the FSM can combine it with its own
    // increment decision without a combinational loop through this module.
    assign last_o = (cnt_q == LAST_C);

endmodule : usr_counter

// File: rtl/univ_shift_reg.sv
// ----------------------------------------------------------------------------
// univ_shift_reg: WIDTH-bit register with parallel load, left/right shift or
// rotate, and a shift counter that flags when a loaded word has fully left.
//   clk_i : clock, all state updates on the rising edge
//   rst_i : synchronous reset, active-high (beats EN and MODE)
//   bus   : univ_shift_reg_if.slave (en, mode, rot, d, sin -> q, sout, cnt, done)
// Every output is a flop; there is no input-to-output combinational path.
// ----------------------------------------------------------------------------
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    univ_shift_reg_if.slave   bus
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;
    state_t           state_q, state_d;

    logic             cnt_clr, cnt_inc, cnt_last;
    logic [CW-1:0]    cnt;
    logic             fill_l, fill_r;
    logic             is_shift;

    usr_counter #(
        .MAX (WIDTH),
        .CW  (CW)
    ) u_counter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    // Bit entering the vacated end: the bit falling off the other end when
    // rotating, otherwise the serial input.
    assign fill_l   = bus.rot ? q_q[WIDTH-1] : bus.sin;
    assign fill_r   = bus.rot ? q_q[0]       : bus.sin;
    assign is_shift = bus.en && ((bus.mode == MODE_SHL) || (bus.mode == MODE_SHR));

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        q_d     = q_q;
        sout_d  = sout_q;
        state_d = state_q;
        done_d  = 1'b0;          // DONE is a pulse: clears on any edge, EN or not
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;

        if (bus.en) begin
            unique case (bus.mode)
                MODE_HOLD: ;
                MODE_LOAD: begin
                    q_d     = bus.d;
                    sout_d  = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = S_ACTIVE;
                end
                MODE_SHL: begin
                    q_d    = {q_q[WIDTH-2:0], fill_l};
                    sout_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d    = {fill_r, q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
            endcase
        end

        // Only shifts taken while ACTIVE count; IDLE and SPENT just move data.
        if (is_shift && (state_q == S_ACTIVE)) begin
            cnt_inc = 1'b1;
            if (cnt_last) begin
                state_d = S_SPENT;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q     <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= S_IDLE;
        end else begin
            q_q     <= q_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.sout = sout_q;
    assign bus.cnt  = cnt;
    assign bus.done = done_q;

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// ----------------------------------------------------------------------------
// tb_univ_shift_reg: vector table for the listed scenarios plus a mixed
// SHL/SHR drain sequence checked against a small bench-side model.
// ----------------------------------------------------------------------------
module tb_univ_shift_reg;
    import usr_pkg::*;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(WIDTH)) bus ();

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        string            name;
        logic             rst;
        logic             en;
        mode_t            mode;
        logic             rot;
        logic [WIDTH-1:0] d;
        logic             sin;
        logic [WIDTH-1:0] q;
        logic             sout;
        logic [CW-1:0]    cnt;
        logic             done;
    } vec_t;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] q;
        logic             sout;
        logic [CW-1:0]    cnt;
        logic             done;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic r, input logic e,
                                input mode_t m, input logic rt, input logic [WIDTH-1:0] d,
                                input logic s, input logic [WIDTH-1:0] q, input logic so,
                                input int c, input logic dn);
        vec_t v;
        v.name = name; v.rst = r; v.en = e; v.mode = m; v.rot = rt; v.d = d; v.sin = s;
        v.q = q; v.sout = so; v.cnt = CW'(c); v.done = dn;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst      = v.rst;
        bus.en   = v.en;
        bus.mode = v.mode;
        bus.rot  = v.rot;
        bus.d    = v.d;
        bus.sin  = v.sin;
        sb.push_back('{v.name, v.q, v.sout, v.cnt, v.done});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.name, ".q"},    32'(bus.q),    32'(e.q));
        check({e.name, ".sout"}, 32'(bus.sout), 32'(e.sout));
        check({e.name, ".cnt"},  32'(bus.cnt),  32'(e.cnt));
        check({e.name, ".done"}, 32'(bus.done), 32'(e.done));
    endtask

    initial begin
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.mode = MODE_HOLD;
        bus.rot  = 1'b0;
        bus.d    = '0;
        bus.sin  = 1'b0;

        // reset beats EN/LOAD; EN low holds; IDLE shifts move data only
        tbl.push_back(mk("rst_load",   1, 1, MODE_LOAD, 0, 8'hFF, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk("en0_load",   0, 0, MODE_LOAD, 0, 8'hFF, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk("idle_shl",   0, 1, MODE_SHL,  0, 8'h00, 1, 8'h01, 0, 0, 0));
        // LOAD A5, 8x SHL sin=0
        tbl.push_back(mk("ld_a5",      0, 1, MODE_LOAD, 0, 8'hA5, 0, 8'hA5, 0, 0, 0));
        tbl.push_back(mk("shl1",       0, 1, MODE_SHL,  0, 8'h00, 0, 8'h4A, 1, 1, 0));
        tbl.push_back(mk("shl2",       0, 1, MODE_SHL,  0, 8'h00, 0, 8'h94, 0, 2, 0));
        tbl.push_back(mk("shl3",       0, 1, MODE_SHL,  0, 8'h00, 0, 8'h28, 1, 3, 0));
        tbl.push_back(mk("shl4",       0, 1, MODE_SHL,  0, 8'h00, 0, 8'h50, 0, 4, 0));
        tbl.push_back(mk("shl5",       0, 1, MODE_SHL,  0, 8'h00, 0, 8'hA0, 0, 5, 0));
        tbl.push_back(mk("shl6",       0, 1, MODE_SHL,  0, 8'h00, 0, 8'h40, 1, 6, 0));
        tbl.push_back(mk("shl7",       0, 1, MODE_SHL,  0, 8'h00, 0, 8'h80, 0, 7, 0));
        tbl.push_back(mk("shl8",       0, 1, MODE_SHL,  0, 8'h00, 0, 8'h00, 1, 8, 1));
        tbl.push_back(mk("hold_spent", 0, 1, MODE_HOLD, 0, 8'h00, 0, 8'h00, 1, 8, 0));
        // LOAD 81, rotate right 8x (sin=1 must be ignored)
        tbl.push_back(mk("ld_81",      0, 1, MODE_LOAD, 0, 8'h81, 0, 8'h81, 0, 0, 0));
        tbl.push_back(mk("ror1",       0, 1, MODE_SHR,  1, 8'h00, 1, 8'hC0, 1, 1, 0));
        tbl.push_back(mk("ror2",       0, 1, MODE_SHR,  1, 8'h00, 1, 8'h60, 0, 2, 0));
        tbl.push_back(mk("ror3",       0, 1, MODE_SHR,  1, 8'h00, 1, 8'h30, 0, 3, 0));
        tbl.push_back(mk("ror4",       0, 1, MODE_SHR,  1, 8'h00, 1, 8'h18, 0, 4, 0));
        tbl.push_back(mk("ror5",       0, 1, MODE_SHR,  1, 8'h00, 1, 8'h0C, 0, 5, 0));
        tbl.push_back(mk("ror6",       0, 1, MODE_SHR,  1, 8'h00, 1, 8'h06, 0, 6, 0));
        tbl.push_back(mk("ror7",       0, 1, MODE_SHR,  1, 8'h00, 1, 8'h03, 0, 7, 0));
        tbl.push_back(mk("ror8",       0, 1, MODE_SHR,  1, 8'h00, 1, 8'h81, 1, 8, 1));
        tbl.push_back(mk("en0_doneclr",0, 0, MODE_SHR,  1, 8'h00, 1, 8'h81, 1, 8, 0));
        // LOAD 0F from SPENT, 3 shifts, EN low x4, 5 shifts, SPENT shifts
        tbl.push_back(mk("ld_0f",      0, 1, MODE_LOAD, 0, 8'h0F, 0, 8'h0F, 0, 0, 0));
        tbl.push_back(mk("f_shl1",     0, 1, MODE_SHL,  0, 8'h00, 1, 8'h1F, 0, 1, 0));
        tbl.push_back(mk("f_shl2",     0, 1, MODE_SHL,  0, 8'h00, 1, 8'h3F, 0, 2, 0));
        tbl.push_back(mk("f_shl3",     0, 1, MODE_SHL,  0, 8'h00, 1, 8'h7F, 0, 3, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk("f_en0",  0, 0, MODE_SHL,  0, 8'h00, 1, 8'h7F, 0, 3, 0));
        tbl.push_back(mk("f_shl4",     0, 1, MODE_SHL,  0, 8'h00, 1, 8'hFF, 0, 4, 0));
        tbl.push_back(mk("f_shl5",     0, 1, MODE_SHL,  0, 8'h00, 1, 8'hFF, 1, 5, 0));
        tbl.push_back(mk("f_shl6",     0, 1, MODE_SHL,  0, 8'h00, 1, 8'hFF, 1, 6, 0));
        tbl.push_back(mk("f_shl7",     0, 1, MODE_SHL,  0, 8'h00, 1, 8'hFF, 1, 7, 0));
        tbl.push_back(mk("f_shl8",     0, 1, MODE_SHL,  0, 8'h00, 1, 8'hFF, 1, 8, 1));
        tbl.push_back(mk("spent_shl",  0, 1, MODE_SHL,  0, 8'h00, 0, 8'hFE, 1, 8, 0));
        tbl.push_back(mk("spent_shr",  0, 1, MODE_SHR,  0, 8'h00, 0, 8'h7F, 0, 8, 0));
        // LOAD from SPENT restarts the count; mixed shifts count once each
        tbl.push_back(mk("ld_3c",      0, 1, MODE_LOAD, 0, 8'h3C, 0, 8'h3C, 0, 0, 0));
        tbl.push_back(mk("r_shl",      0, 1, MODE_SHL,  0, 8'h00, 0, 8'h78, 0, 1, 0));
        tbl.push_back(mk("r_shr",      0, 1, MODE_SHR,  0, 8'h00, 0, 8'h3C, 0, 2, 0));
        tbl.push_back(mk("r_hold",     0, 1, MODE_HOLD, 0, 8'h00, 0, 8'h3C, 0, 2, 0));
        // LOAD 55, 7x SHR, RST with the 8th shift suppresses DONE
        tbl.push_back(mk("ld_55",      0, 1, MODE_LOAD, 0, 8'h55, 0, 8'h55, 0, 0, 0));
        tbl.push_back(mk("a_shr1",     0, 1, MODE_SHR,  0, 8'h00, 0, 8'h2A, 1, 1, 0));
        tbl.push_back(mk("a_shr2",     0, 1, MODE_SHR,  0, 8'h00, 0, 8'h15, 0, 2, 0));
        tbl.push_back(mk("a_shr3",     0, 1, MODE_SHR,  0, 8'h00, 0, 8'h0A, 1, 3, 0));
        tbl.push_back(mk("a_shr4",     0, 1, MODE_SHR,  0, 8'h00, 0, 8'h05, 0, 4, 0));
        tbl.push_back(mk("a_shr5",     0, 1, MODE_SHR,  0, 8'h00, 0, 8'h02, 1, 5, 0));
        tbl.push_back(mk("a_shr6",     0, 1, MODE_SHR,  0, 8'h00, 0, 8'h01, 0, 6, 0));
        tbl.push_back(mk("a_shr7",     0, 1, MODE_SHR,  0, 8'h00, 0, 8'h00, 1, 7, 0));
        tbl.push_back(mk("a_rst_shr8", 1, 1, MODE_SHR,  0, 8'h00, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk("a_idle_shr", 0, 1, MODE_SHR,  0, 8'h00, 1, 8'h80, 0, 0, 0));
        tbl.push_back(mk("a_idle_shl", 0, 1, MODE_SHL,  0, 8'h00, 0, 8'h00, 1, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Mixed-direction drain of a few words; DONE must arrive on shift WIDTH,
        // with the wait bounded so a missing pulse fails instead of hanging.
        begin
            logic [WIDTH-1:0] words[3];
            words[0] = 8'hB6; words[1] = 8'h3D; words[2] = 8'hE1;
            foreach (words[w]) begin
                logic [WIDTH-1:0] m;
                int               done_at;
                vec_t             v;
                m       = words[w];
                done_at = 0;
                step(mk("drain_ld", 0, 1, MODE_LOAD, 0, m, 0, m, 0, 0, 0));
                for (int i = 1; i <= 2 * WIDTH; i++) begin
                    logic s, so;
                    mode_t md;
                    s  = 1'($urandom_range(0, 1));
                    md = (i % 2 == 0) ? MODE_SHL : MODE_SHR;
                    if (md == MODE_SHL) begin
                        so = m[WIDTH-1];
                        m  = {m[WIDTH-2:0], s};
                    end else begin
                        so = m[0];
                        m  = {s, m[WIDTH-1:1]};
                    end
                    v = mk("drain_sh", 0, 1, md, 0, 8'h00, s, m, so,
                           (i < WIDTH) ? i : WIDTH, (i == WIDTH) ? 1'b1 : 1'b0);
                    step(v);
                    if (bus.done === 1'b1) begin
                        done_at = i;
                        break;
                    end
                end
                check("drain_done_at", 32'(done_at), 32'(WIDTH));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_univ_shift_reg
